// File: rtl/shifter_pkg.sv
// Shared types and constants for the pipelined barrel shifter.
package shifter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shift_stage.sv
// One combinational mux stage of the barrel shifter: shifts or rotates by DIST when enabled.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  shift_op_e        i_op,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      unique case (i_op)
        OP_SRL: o_data = i_data >> DIST;
        OP_SRA: o_data = $signed(i_data) >>> DIST;
        OP_SLL: o_data = i_data << DIST;
        OP_ROR: o_data = (i_data >> DIST) | (i_data << (WIDTH - DIST));
        default: o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SRL/SRA/SLL/ROR) with a global-stall valid/ready handshake.
// Optional status outputs out_zero/out_carry are enabled by defining SHIFTER_STATUS_EN.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH          = DEFAULT_WIDTH,
  parameter int unsigned STAGES_PER_REG = 2,
  parameter int unsigned TAG_W          = 4,
  localparam int unsigned LOG2W         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFTER_STATUS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  localparam int unsigned NREG = (LOG2W + STAGES_PER_REG - 1) / STAGES_PER_REG;

  logic w_adv;

  logic [NREG-1:0]            r_valid;
  logic [NREG-1:0][WIDTH-1:0] r_data;
  logic [NREG-1:0][1:0]       r_op;
  logic [NREG-1:0][LOG2W-1:0] r_shamt;
  logic [NREG-1:0][TAG_W-1:0] r_tag;

  // Per-group inputs (from the ports or the previous register) and group outputs.
  logic [NREG-1:0]            w_gvalid;
  logic [NREG-1:0][WIDTH-1:0] w_gdata;
  logic [NREG-1:0][1:0]       w_gop;
  logic [NREG-1:0][LOG2W-1:0] w_gshamt;
  logic [NREG-1:0][TAG_W-1:0] w_gtag;
  logic [NREG-1:0][WIDTH-1:0] w_gout;

  logic [LOG2W-1:0][WIDTH-1:0] w_sin;
  logic [LOG2W-1:0][WIDTH-1:0] w_sout;

  assign w_adv     = out_ready | ~r_valid[NREG-1];
  assign in_ready  = w_adv;
  assign out_valid = r_valid[NREG-1];
  assign out_data  = r_data[NREG-1];
  assign out_tag   = r_tag[NREG-1];

  for (genvar j = 0; j < NREG; j++) begin : g_grp
    localparam int unsigned LAST = ((j + 1) * STAGES_PER_REG < LOG2W) ?
                                   (j + 1) * STAGES_PER_REG - 1 : LOG2W - 1;
    if (j == 0) begin : g_src_in
      assign w_gvalid[j] = in_valid;
      assign w_gdata[j]  = in_data;
      assign w_gop[j]    = in_op;
      assign w_gshamt[j] = in_shamt;
      assign w_gtag[j]   = in_tag;
    end else begin : g_src_reg
      assign w_gvalid[j] = r_valid[j-1];
      assign w_gdata[j]  = r_data[j-1];
      assign w_gop[j]    = r_op[j-1];
      assign w_gshamt[j] = r_shamt[j-1];
      assign w_gtag[j]   = r_tag[j-1];
    end
    assign w_gout[j] = w_sout[LAST];
  end

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    localparam int unsigned J = k / STAGES_PER_REG;
    if (k % STAGES_PER_REG == 0) begin : g_first
      assign w_sin[k] = w_gdata[J];
    end else begin : g_chain
      assign w_sin[k] = w_sout[k-1];
    end

    shift_stage #(
      .WIDTH(WIDTH),
      .DIST (2 ** k)
    ) u_stage (
      .i_data(w_sin[k]),
      .i_op  (shift_op_e'(w_gop[J])),
      .i_en  (w_gshamt[J][k]),
      .o_data(w_sout[k])
    );
  end

  // Every register moves together on advance, so a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
      r_op    <= '0;
      r_shamt <= '0;
      r_tag   <= '0;
    end else if (w_adv) begin
      r_valid <= w_gvalid;
      r_data  <= w_gout;
      r_op    <= w_gop;
      r_shamt <= w_gshamt;
      r_tag   <= w_gtag;
    end
  end

`ifdef SHIFTER_STATUS_EN
  logic [NREG-1:0]  r_carry;
  logic             r_zero;
  logic [NREG-1:0]  w_gcarry;
  logic [NREG-1:0]  w_rcarry;
  logic [LOG2W-1:0] w_cin;
  logic [LOG2W-1:0] w_cout;

  // Carry is tracked incrementally: each enabled stage records the last bit it pushes out.
  for (genvar k = 0; k < LOG2W; k++) begin : g_carry
    localparam int unsigned J    = k / STAGES_PER_REG;
    localparam int unsigned DIST = 2 ** k;
    if (k % STAGES_PER_REG == 0) begin : g_first
      assign w_cin[k] = w_gcarry[J];
    end else begin : g_chain
      assign w_cin[k] = w_cout[k-1];
    end
    assign w_cout[k] = !w_gshamt[J][k]                              ? w_cin[k] :
                       (w_gop[J] == OP_SRL || w_gop[J] == OP_SRA)   ? w_sin[k][DIST-1] :
                       (w_gop[J] == OP_SLL)                         ? w_sin[k][WIDTH-DIST] :
                                                                      1'b0;
  end

  for (genvar j = 0; j < NREG; j++) begin : g_cgrp
    localparam int unsigned LAST = ((j + 1) * STAGES_PER_REG < LOG2W) ?
                                   (j + 1) * STAGES_PER_REG - 1 : LOG2W - 1;
    if (j == 0) begin : g_src_in
      assign w_gcarry[j] = 1'b0;
    end else begin : g_src_reg
      assign w_gcarry[j] = r_carry[j-1];
    end
    if (j == NREG - 1) begin : g_final
      assign w_rcarry[j] = (w_gop[j] == OP_ROR) ? (|w_gshamt[j] & w_gout[j][WIDTH-1]) :
                                                  w_cout[LAST];
    end else begin : g_mid
      assign w_rcarry[j] = w_cout[LAST];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= '0;
      r_zero  <= 1'b0;
    end else if (w_adv) begin
      r_carry <= w_rcarry;
      r_zero  <= (w_gout[NREG-1] == '0);
    end
  end

  assign out_zero  = r_zero;
  assign out_carry = r_carry[NREG-1];
`endif

  // Last-stage op/shamt and non-local shamt bits are carried only for uniformity.
  logic w_unused;
  assign w_unused = ^{r_op, r_shamt, w_gshamt};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed cases, backpressure, reset, random.
// Status outputs are checked when SHIFTER_STATUS_EN is defined.
module tb_pipelined_barrel_shifter;

  localparam int W   = 32;
  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
`ifdef SHIFTER_STATUS_EN
  logic        out_zero;
  logic        out_carry;
`endif

  pipelined_barrel_shifter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
`ifdef SHIFTER_STATUS_EN
    ,
    .out_zero (out_zero),
    .out_carry(out_carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        zero;
    logic        carry;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  bit   rand_ready = 0;

  // Reference: shifts computed on wide integers rather than stage by stage.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s,
                                            input logic [1:0] op);
    logic [63:0] w;
    case (op)
      2'b00:   return d >> s;
      2'b01:   begin w = {{32{d[31]}}, d}; w = w >> s; return w[31:0]; end
      2'b10:   return d << s;
      default: begin w = {d, d}; w = w >> s; return w[31:0]; end
    endcase
  endfunction

  function automatic logic ref_carry(input logic [31:0] d, input int s, input logic [1:0] op);
    logic [31:0] r;
    r = ref_shift(d, s, op);
    if (s == 0) return 1'b0;
    case (op)
      2'b00, 2'b01: return d[s-1];
      2'b10:        return d[W-s];
      default:      return r[31];
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor: compare every consumed output against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got tag %h data %h expected none", out_tag, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        check("out_data", out_data, e.data);
        check("out_tag", 32'(out_tag), 32'(e.tag));
`ifdef SHIFTER_STATUS_EN
        check("out_zero", 32'(out_zero), 32'(e.zero));
        check("out_carry", 32'(out_carry), 32'(e.carry));
`endif
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] d, input int s, input logic [1:0] op,
                      input logic [3:0] tag, input logic [31:0] exp_data);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = 5'(s);
    in_op    = op;
    in_tag   = tag;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      e.data  = exp_data;
      e.tag   = tag;
      e.zero  = (exp_data == 32'd0);
      e.carry = ref_carry(d, s, op);
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_rand(input logic [3:0] tag);
    logic [31:0] d;
    int          s;
    logic [1:0]  op;
    d  = $urandom;
    s  = $urandom_range(0, W - 1);
    op = 2'($urandom_range(0, 3));
    send(d, s, op, tag, ref_shift(d, s, op));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic latency_check(input string nm);
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check(nm, 32'(lat), 32'(LAT));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_data;
    logic [3:0]  hold_tag;
    int          p0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Directed cases.
    send(32'h8000_0001, 1, 2'b00, 4'd3, 32'h4000_0000);
    latency_check("latency_first");
    send(32'h8000_0000, 4, 2'b01, 4'd4, 32'hF800_0000);
    send(32'h7000_0000, 4, 2'b01, 4'd5, 32'h0700_0000);
    send(32'h0000_0001, 31, 2'b10, 4'd6, 32'h8000_0000);
    send(32'h0000_0003, 1, 2'b11, 4'd7, 32'h8000_0001);
    for (int op = 0; op < 4; op++) send(32'hDEAD_BEEF, 0, 2'(op), 4'(8 + op), 32'hDEAD_BEEF);
    send(32'h0000_0001, 1, 2'b00, 4'd12, 32'h0000_0000);
    send(32'h4000_0000, 2, 2'b10, 4'd13, 32'h0000_0000);
    drain();

    // Backpressure: stall the consumer while six beats stream in.
    @(posedge clk);
    #1 out_ready = 1'b0;
    p0 = pops;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand(4'(i));
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("stall_out_valid", 32'(out_valid), 32'd1);
        hold_data = out_data;
        hold_tag  = out_tag;
        repeat (5) begin
          @(negedge clk);
          check("stall_data_stable", out_data, hold_data);
          check("stall_tag_stable", 32'(out_tag), 32'(hold_tag));
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_beat_count", 32'(pops - p0), 32'd6);

    // Reset with beats in flight.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) send_rand(4'(9 + i));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_out_tag", 32'(out_tag), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    send(32'h0000_00F0, 4, 2'b00, 4'd14, 32'h0000_000F);
    latency_check("latency_after_reset");
    drain();

    // Random traffic with random consumer stalls and input gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_rand(4'($urandom));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter for the 32-bit datapath ALU. It supports logical right, arithmetic right, logical left and rotate right. Shift amount is decoded in log2(WIDTH) mux stages, with pipeline registers inserted every STAGES_PER_REG stages. A valid/ready handshake sits on both sides so the ALU issue logic can stall it.

Parameters:
WIDTH, 32, data width; power of two, ≥4
LOG2W, $clog2(WIDTH), shift-amount width / number of mux stages (derived; not overridable)
STAGES_PER_REG, 2, mux stages between pipeline registers; 1..LOG2W
TAG_W, 4, width of sideband tag carried alongside data

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat this cycle
in_data  in  WIDTH  operand
in_shamt  in  LOG2W  shift amount, 0..WIDTH-1
in_op  in  2  00 SRL, 01 SRA, 10 SLL, 11 ROR
in_tag  in  TAG_W  sideband, returned unchanged with result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  shifted result
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits clear. out_valid=0, out_data=0, out_tag=0, all pipeline data registers=0. Release is synchronous to clk.
- Mux stage k (k=0..LOG2W-1) shifts by 2^k when shamt[k]=1 and passes data through otherwise.
- SRL fill: zeros. SRA fill: operand MSB (sign). SLL fill: zeros. ROR: bits shifted out of bit 0 re-enter at bit WIDTH-1.
- op, shamt and tag travel with the data through every register.
- Registers sit after stages STAGES_PER_REG-1, 2·STAGES_PER_REG-1, …; the last stage is always followed by a register.
- Latency L = ceil(LOG2W/STAGES_PER_REG) cycles from accepted input to out_valid. Defaults: L=3.
- shamt=0 → out_data = in_data for every op.
- Handshake: global stall. adv = out_ready | ~out_valid; in_ready = adv.
  - adv=1: every stage register loads its predecessor (data + valid).
  - adv=0: every register holds its value.
- Input accepted iff in_valid & in_ready. Output consumed iff out_valid & out_ready.
- Throughput is 1 beat/cycle when out_ready stays high. Bubbles propagate as valid=0.
- While out_valid=1 and out_ready=0, out_data and out_tag hold stable and in_ready=0.
- in_valid while in_ready=0: beat is ignored; the source must hold it.
- Ordering is strictly preserved; no beat is dropped or duplicated.
- Reset mid-operation: all in-flight beats are discarded; no output appears after reset release until new inputs traverse L cycles.

Optional Feature:
SHIFTER_STATUS_EN adds two outputs, out_zero (1) and out_carry (1), aligned with out_data and reset to 0.
- out_zero = (out_data==0).
- out_carry, when shamt≠0:
  - SRL/SRA: last bit shifted out, in_data[shamt-1].
  - SLL: in_data[WIDTH-shamt].
  - ROR: out_data[WIDTH-1].
- out_carry = 0 when shamt=0.
- Without the macro, the ports and their logic are absent. Data path and timing are identical either way.

Decomposition:
- Package shifter_pkg:
  - shift_op_e enum (OP_SRL=2'b00, OP_SRA=2'b01, OP_SLL=2'b10, OP_ROR=2'b11).
  - Constant DEFAULT_WIDTH=32.
- Sub-module shift_stage: combinational single stage, parameters WIDTH and DIST (=2^k). Inputs data, op, en; output data. Instantiated LOG2W times via generate.
- Pipeline registers and handshake live in the top module.

Test Plan:
- SRL, in_data=0x8000_0001, shamt=1, tag=3 → after 3 cycles out_data=0x4000_0000, out_tag=3.
- SRA, 0x8000_0000, shamt=4 → 0xF800_0000. SRA 0x7000_0000 shamt=4 → 0x0700_0000.
- SLL, 0x0000_0001, shamt=31 → 0x8000_0000. ROR 0x0000_0003 shamt=1 → 0x8000_0001. Any op with shamt=0 on 0xDEAD_BEEF → 0xDEAD_BEEF.
- Backpressure: stream 6 beats with tags 0..5, out_ready=0 for 5 cycles then 1.
  - While stalled, out_data/out_tag are stable and in_ready=0.
  - After release, all results emerge in tag order 0..5 with none lost or duplicated.
- Reset: with 3 beats in flight, pulse rst_n low mid-cycle → outputs clear immediately. No out_valid until a new beat is accepted and L cycles elapse.
- With SHIFTER_STATUS_EN:
  - SRL 0x0000_0001 shamt=1 → out_data=0, out_zero=1, out_carry=1.
  - SLL 0x4000_0000 shamt=2 → out_carry=1.
  - Random ops checked against a reference model.
